// File: rtl/matrix_feeder.sv
// matrix_feeder: run-time loadable ARRAY_W x ARRAY_L operand buffer that
// streams one column per cycle into the row inputs of a systolic array.
// Each lane carries a valid flag. A start/busy/done handshake frames a stream.
// Optional feature macro: FEEDER_SKEW_EN. When it is defined, lane i is
// delayed by i cycles (diagonal skew) and the stream is ARRAY_L+ARRAY_W-1
// steps long. When it is not defined, all lanes are valid on every step and
// the stream is ARRAY_L steps long.
module matrix_feeder #(
  parameter int DATA_WIDTH = 8,
  parameter int ARRAY_W    = 5,
  parameter int ARRAY_L    = 2
) (
  input  logic                                              clk,
  input  logic                                              reset_n,
  input  logic                                              wr_en,
  input  logic [((ARRAY_W > 1) ? $clog2(ARRAY_W) : 1)-1:0]  wr_row,
  input  logic [((ARRAY_L > 1) ? $clog2(ARRAY_L) : 1)-1:0]  wr_col,
  input  logic [DATA_WIDTH-1:0]                             wr_data,
  input  logic                                              start,
  output logic                                              busy,
  output logic                                              done,
  output logic [0:ARRAY_W-1][DATA_WIDTH-1:0]                out_data,
  output logic [0:ARRAY_W-1]                                out_valid
);

`ifdef FEEDER_SKEW_EN
  localparam int STEPS = ARRAY_L + ARRAY_W - 1;
`else
  localparam int STEPS = ARRAY_L;
`endif
  localparam int STEP_W = $clog2(STEPS + 1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                              r_state;
  logic [STEP_W-1:0]                   r_step;
  logic                                r_busy;
  logic                                r_done;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]  r_outData;
  logic [0:ARRAY_W-1]                  r_outValid;
  logic [DATA_WIDTH-1:0]               r_mem [ARRAY_W][ARRAY_L];

  logic                                w_writeOk;
  logic [STEP_W-1:0]                   w_nextStep;
  logic [0:ARRAY_W-1][DATA_WIDTH-1:0]  w_beatData;
  logic [0:ARRAY_W-1]                  w_beatValid;

  // Writes are only honoured while idle and with both indices inside the matrix
  assign w_writeOk = wr_en && (r_state == IDLE) &&
                     (int'(wr_row) < ARRAY_W) && (int'(wr_col) < ARRAY_L);

  // Step that the next registered beat will show: 0 on stream entry, else current+1
  assign w_nextStep = (r_state == IDLE) ? '0 : (r_step + STEP_W'(1));

  // Operand storage, cleared by reset and written only through the idle write port
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ARRAY_W; i++) begin
        for (int k = 0; k < ARRAY_L; k++) begin
          r_mem[i][k] <= '0;
        end
      end
    end else if (w_writeOk) begin
      r_mem[wr_row][wr_col] <= wr_data;
    end
  end

  // Build the beat for the next step; a write on the start edge is forwarded so step 0 sees it
  always_comb begin
    w_beatData  = '0;
    w_beatValid = '0;
    for (int i = 0; i < ARRAY_W; i++) begin
      for (int k = 0; k < ARRAY_L; k++) begin
`ifdef FEEDER_SKEW_EN
        if (int'(w_nextStep) == i + k) begin
`else
        if (int'(w_nextStep) == k) begin
`endif
          w_beatValid[i] = 1'b1;
          w_beatData[i]  = (w_writeOk && (int'(wr_row) == i) && (int'(wr_col) == k)) ?
                           wr_data : r_mem[i][k];
        end
      end
    end
  end

  // Stream sequencer with registered busy/done and lane outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_step     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_outData  <= '0;
      r_outValid <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_state    <= STREAM;
            r_step     <= '0;
            r_busy     <= 1'b1;
            r_outData  <= w_beatData;
            r_outValid <= w_beatValid;
          end
        end
        STREAM: begin
          if (r_step == LAST_STEP) begin
            r_state    <= IDLE;
            r_step     <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
            r_outData  <= '0;
            r_outValid <= '0;
          end else begin
            r_step     <= w_nextStep;
            r_outData  <= w_beatData;
            r_outValid <= w_beatValid;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign done      = r_done;
  assign out_data  = r_outData;
  assign out_valid = r_outValid;

endmodule

// File: tb/tb_matrix_feeder.sv
// Scoreboard bench for matrix_feeder: stimulus pushes expected beats, a
// negedge monitor pops and compares whenever the feeder is busy or done.
module tb_matrix_feeder;

  localparam int DW = 8;
  localparam int W  = 5;
  localparam int L  = 2;
`ifdef FEEDER_SKEW_EN
  localparam int S  = L + W - 1;
`else
  localparam int S  = L;
`endif

  typedef struct {
    logic [0:W-1][DW-1:0] data;
    logic [0:W-1]         valid;
    bit                   isDone;
  } beat_t;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic                  wr_en;
  logic [2:0]            wr_row;
  logic [0:0]            wr_col;
  logic [DW-1:0]         wr_data;
  logic                  start;
  logic                  busy;
  logic                  done;
  logic [0:W-1][DW-1:0]  out_data;
  logic [0:W-1]          out_valid;

  beat_t                 expected[$];
  logic [DW-1:0]         modelMem [W][L];
  int                    checkCount = 0;
  int                    passCount  = 0;

  matrix_feeder #(.DATA_WIDTH(DW), .ARRAY_W(W), .ARRAY_L(L)) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_row(wr_row),
    .wr_col(wr_col), .wr_data(wr_data), .start(start), .busy(busy),
    .done(done), .out_data(out_data), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  // One comparison: count it, report a FAIL line on mismatch
  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] want);
    checkCount++;
    if (actual !== want) begin
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, want);
    end else begin
      passCount++;
    end
  endtask

  // Write one entry at the next edge; the model follows only in-range writes
  task automatic applyStimulus(input int row, input int col, input logic [DW-1:0] val);
    wr_en   = 1'b1;
    wr_row  = row[2:0];
    wr_col  = col[0:0];
    wr_data = val;
    if (row < W && col < L) modelMem[row][col] = val;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic loadAll();
    for (int i = 0; i < W; i++)
      for (int k = 0; k < L; k++)
        applyStimulus(i, k, DW'(10 * i + k + 1));
  endtask

  // Push the expected beats of one stream, derived from the model contents
  task automatic pushStream();
    beat_t b;
    for (int s = 0; s < S; s++) begin
      b.data = '0; b.valid = '0; b.isDone = 1'b0;
      for (int i = 0; i < W; i++) begin
`ifdef FEEDER_SKEW_EN
        if (s - i >= 0 && s - i < L) begin
          b.valid[i] = 1'b1;
          b.data[i]  = modelMem[i][s - i];
        end
`else
        b.valid[i] = 1'b1;
        b.data[i]  = modelMem[i][s];
`endif
      end
      expected.push_back(b);
    end
    b.data = '0; b.valid = '0; b.isDone = 1'b1;
    expected.push_back(b);
  endtask

  // Hand-computed beats for A[i][k] = 10*i+k+1
  task automatic pushHand();
    beat_t b;
    b.isDone = 1'b0;
`ifdef FEEDER_SKEW_EN
    b.data = {8'd1, 8'd0, 8'd0, 8'd0, 8'd0};   b.valid = 5'b10000; expected.push_back(b);
    b.data = {8'd2, 8'd11, 8'd0, 8'd0, 8'd0};  b.valid = 5'b11000; expected.push_back(b);
    b.data = {8'd0, 8'd12, 8'd21, 8'd0, 8'd0}; b.valid = 5'b01100; expected.push_back(b);
    b.data = {8'd0, 8'd0, 8'd22, 8'd31, 8'd0}; b.valid = 5'b00110; expected.push_back(b);
    b.data = {8'd0, 8'd0, 8'd0, 8'd32, 8'd41}; b.valid = 5'b00011; expected.push_back(b);
    b.data = {8'd0, 8'd0, 8'd0, 8'd0, 8'd42};  b.valid = 5'b00001; expected.push_back(b);
`else
    b.data = {8'd1, 8'd11, 8'd21, 8'd31, 8'd41}; b.valid = 5'b11111; expected.push_back(b);
    b.data = {8'd2, 8'd12, 8'd22, 8'd32, 8'd42}; b.valid = 5'b11111; expected.push_back(b);
`endif
    b.data = '0; b.valid = '0; b.isDone = 1'b1;
    expected.push_back(b);
  endtask

  // Pulse start for one edge, then let the stream and its done pulse finish
  task automatic startPulse();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (S) @(posedge clk);
    #1;
  endtask

  // Monitor: every busy or done cycle must match the head of the scoreboard
  always @(negedge clk) begin
    beat_t b;
    if (reset_n === 1'b1 && (busy !== 1'b0 || done !== 1'b0)) begin
      if (expected.size() == 0) begin
        checkCount++;
        $display("[TB] FAIL unexpected output: got busy=%b done=%b, expected idle", busy, done);
      end else begin
        b = expected.pop_front();
        if (b.isDone) begin
          checkOutput("done flags", {62'd0, busy, done}, 64'h1);
          checkOutput("done data", 64'(out_data), 64'h0);
          checkOutput("done valid", 64'(out_valid), 64'h0);
        end else begin
          checkOutput("beat flags", {62'd0, busy, done}, 64'h2);
          checkOutput("beat data", 64'(out_data), 64'(b.data));
          checkOutput("beat valid", 64'(out_valid), 64'(b.valid));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; start = 1'b0;
    for (int i = 0; i < W; i++)
      for (int k = 0; k < L; k++)
        modelMem[i][k] = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset busy", {63'd0, busy}, 64'h0);
    checkOutput("reset done", {63'd0, done}, 64'h0);
    checkOutput("reset data", 64'(out_data), 64'h0);
    checkOutput("reset valid", 64'(out_valid), 64'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] load and first stream");
    loadAll();
    pushHand();
    startPulse();

    $display("[TB] out-of-range writes");
    applyStimulus(6, 0, 8'hEE);
    applyStimulus(5, 1, 8'hDD);
    applyStimulus(7, 1, 8'hCC);
    pushStream();
    startPulse();

    $display("[TB] write during stream");
    pushStream();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wr_en = 1'b1; wr_row = 3'd2; wr_col = 1'b1; wr_data = 8'h7F;
    @(posedge clk); #1;
    wr_en = 1'b0;
    repeat (S - 1) @(posedge clk);
    #1;
    pushStream();
    startPulse();

    $display("[TB] write and start on same edge");
    wr_en = 1'b1; wr_row = 3'd3; wr_col = 1'b0; wr_data = 8'h55;
    modelMem[3][0] = 8'h55;
    pushStream();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; wr_en = 1'b0;
    repeat (S) @(posedge clk);
    #1;

    $display("[TB] reset mid-stream");
    pushStream();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    expected.delete();
    #1;
    checkOutput("abort busy", {63'd0, busy}, 64'h0);
    checkOutput("abort done", {63'd0, done}, 64'h0);
    checkOutput("abort data", 64'(out_data), 64'h0);
    checkOutput("abort valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < W; i++)
      for (int k = 0; k < L; k++)
        modelMem[i][k] = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    repeat (S + 2) @(posedge clk);
    #1;
    pushStream();
    startPulse();

    $display("[TB] start held high");
    loadAll();
    pushStream(); pushStream(); pushStream();
    start = 1'b1;
    @(posedge clk);
    repeat (3 * S + 2) @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    checkOutput("scoreboard drained", 64'(expected.size()), 64'h0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
